pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipelined ARMv8 CPU. It watches the ID, EX and MEM stages and the data-memory handshake, then drives the write-enable and flush controls of the PC and the IFDE, IDEX, EXMEM and MEMWB pipeline registers. It resolves load-use hazards, taken branches and multi-cycle data-memory accesses, and keeps saturating stall/flush performance counters. A memory-timeout watchdog freezes the pipeline if an access never completes.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/sat_counter.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The control struct is also consumed by the CPU top.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StError
    } state_e;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic pc_we;
        logic ifde_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifde_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    // Field order: pc, ifde, idex, exmem, memwb enables, then ifde, idex, exmem flushes.
    localparam pipe_ctrl_t CtrlRun    = 8'b11111_000;
    localparam pipe_ctrl_t CtrlHold   = 8'b00000_000;
    localparam pipe_ctrl_t CtrlBranch = 8'b11111_111;
    localparam pipe_ctrl_t CtrlBubble = 8'b00111_010;
    localparam pipe_ctrl_t CtrlReset  = 8'b01111_111;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all ones instead of wrapping.
// Synchronous clear has priority over increment.
module sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken-branch
// squashes, memory-wait stalls with a timeout watchdog, and saturating event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_Rn,
    input  logic [4:0]       id_Rm,
    input  logic             id_usesRn,
    input  logic             id_usesRm,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_destreg,
    input  logic             mem_BrTaken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifde_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifde_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] Timeout = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_err_q, mem_err_d;
    logic       memstall, loaduse;
    logic       stall_inc, flush_inc;
    pipe_ctrl_t ctrl;

    assign memstall = mem_req & ~mem_ready;
    assign loaduse  = ex_MemRead & (ex_destreg != XZR) &
                      ((id_usesRn & (id_Rn == ex_destreg)) |
                       (id_usesRm & (id_Rm == ex_destreg)));

    always_comb begin
        ctrl = CtrlRun;
        if (reset) begin
            ctrl = CtrlReset;
        end else if (state_q == StError || memstall) begin
            ctrl = CtrlHold;
        end else if (mem_BrTaken) begin
            ctrl = CtrlBranch;
        end else if (loaduse) begin
            ctrl = CtrlBubble;
        end
    end

    // Events are counted only when the corresponding action is actually applied.
    assign stall_inc = ~reset & (state_q != StError) & (memstall | (loaduse & ~mem_BrTaken));
    assign flush_inc = ~reset & (state_q != StError) & ~memstall & mem_BrTaken;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        if (reset) begin
            state_d   = StRun;
            wait_d    = '0;
            mem_err_d = 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (memstall) begin
                        state_d = StMemWait;
                        wait_d  = 8'd1;
                    end
                end
                StMemWait: begin
                    if (!memstall) begin
                        state_d = StRun;
                        wait_d  = '0;
                    end else if (wait_q >= Timeout) begin
                        state_d   = StError;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                StError: ;
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        wait_q    <= wait_d;
        mem_err_q <= mem_err_d;
    end

    sat_counter #(
        .Width(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clear(reset),
        .inc  (stall_inc),
        .count(stall_cnt)
    );

    sat_counter #(
        .Width(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .clear(reset),
        .inc  (flush_inc),
        .count(flush_cnt)
    );

    assign pc_we       = ctrl.pc_we;
    assign ifde_we     = ctrl.ifde_we;
    assign idex_we     = ctrl.idex_we;
    assign exmem_we    = ctrl.exmem_we;
    assign memwb_we    = ctrl.memwb_we;
    assign ifde_flush  = ctrl.ifde_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a behavioural model feeds a scoreboard
// of expected outputs that is compared against the DUT each cycle.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned Timeout = 4;
    localparam int unsigned CntW    = 4;
    localparam int          CntMax  = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      id_Rn, id_Rm, ex_destreg;
    logic            id_usesRn, id_usesRm, ex_MemRead;
    logic            mem_BrTaken, mem_req, mem_ready;
    logic            pc_we, ifde_we, idex_we, exmem_we, memwb_we;
    logic            ifde_flush, idex_flush, exmem_flush, mem_err;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(Timeout),
        .CNT_W      (CntW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .id_Rn      (id_Rn),
        .id_Rm      (id_Rm),
        .id_usesRn  (id_usesRn),
        .id_usesRm  (id_usesRm),
        .ex_MemRead (ex_MemRead),
        .ex_destreg (ex_destreg),
        .mem_BrTaken(mem_BrTaken),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ifde_we    (ifde_we),
        .idex_we    (idex_we),
        .exmem_we   (exmem_we),
        .memwb_we   (memwb_we),
        .ifde_flush (ifde_flush),
        .idex_flush (idex_flush),
        .exmem_flush(exmem_flush),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    typedef struct packed {
        logic [8:0]      ctrl;
        logic [CntW-1:0] stall;
        logic [CntW-1:0] flush;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // Reference model state: 0 run, 1 memory wait, 2 error.
    int m_st    = 0;
    int m_wait  = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_memstall();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit m_loaduse();
        return ex_MemRead && (ex_destreg != 5'd31) &&
               ((id_usesRn && id_Rn == ex_destreg) || (id_usesRm && id_Rm == ex_destreg));
    endfunction

    // Bits: pc, ifde, idex, exmem, memwb enables; ifde, idex, exmem flushes; mem_err.
    function automatic logic [8:0] m_ctrl();
        if (reset)                 return {8'b01111_111, m_err};
        if (m_st == 2)             return 9'b00000_000_1;
        if (m_memstall())          return {8'b00000_000, m_err};
        if (mem_BrTaken)           return {8'b11111_111, m_err};
        if (m_loaduse())           return {8'b00111_010, m_err};
        return {8'b11111_000, m_err};
    endfunction

    task automatic m_update();
        bit ms, lu;
        ms = m_memstall();
        lu = m_loaduse();
        if (reset) begin
            m_st = 0; m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_st != 2) begin
                if ((ms || (lu && !mem_BrTaken)) && m_stall < CntMax) m_stall++;
                if (!ms && mem_BrTaken && m_flush < CntMax) m_flush++;
            end
            case (m_st)
                0: if (ms) begin m_st = 1; m_wait = 1; end
                1: begin
                    if (!ms) m_st = 0;
                    else if (m_wait == Timeout) begin m_st = 2; m_err = 1'b1; end
                    else m_wait++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input bit rst, input bit mrd, input logic [4:0] dest,
                         input logic [4:0] rn, input bit urn, input logic [4:0] rm, input bit urm,
                         input bit br, input bit req, input bit rdy);
        reset = rst; ex_MemRead = mrd; ex_destreg = dest;
        id_Rn = rn; id_usesRn = urn; id_Rm = rm; id_usesRm = urm;
        mem_BrTaken = br; mem_req = req; mem_ready = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
    endtask

    // Called just after a falling edge with inputs applied.
    task automatic cycle(input string tag);
        exp_t e;
        logic [8:0] obs;
        string t;
        exp_q.push_back('{ctrl: m_ctrl(), stall: CntW'(m_stall), flush: CntW'(m_flush)});
        tag_q.push_back(tag);
        #1;
        obs = {pc_we, ifde_we, idex_we, exmem_we, memwb_we,
               ifde_flush, idex_flush, exmem_flush, mem_err};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq({t, "/ctrl"}, 32'(obs), 32'(e.ctrl));
        check_eq({t, "/stall_cnt"}, 32'(stall_cnt), 32'(e.stall));
        check_eq({t, "/flush_cnt"}, 32'(flush_cnt), 32'(e.flush));
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);

        cycle("reset0");
        cycle("reset1");
        idle();
        cycle("idle");

        drive(0, 1, 5'd3, 5'd3, 1, 5'd0, 0, 0, 0, 1);
        cycle("ld_rn");
        check_eq("ld_rn_stall_cnt", 32'(stall_cnt), 32'd1);
        idle();
        cycle("after_ld");

        drive(0, 1, 5'd31, 5'd31, 1, 5'd31, 1, 0, 0, 1);
        cycle("ld_xzr");
        check_eq("ld_xzr_stall_cnt", 32'(stall_cnt), 32'd1);
        drive(0, 1, 5'd7, 5'd0, 0, 5'd7, 1, 0, 0, 1);
        cycle("ld_rm");
        drive(0, 1, 5'd7, 5'd7, 0, 5'd7, 0, 0, 0, 1);
        cycle("ld_unused");
        check_eq("ld_rm_stall_cnt", 32'(stall_cnt), 32'd2);

        drive(0, 1, 5'd3, 5'd3, 1, 5'd0, 0, 1, 0, 1);
        cycle("br_lu");
        check_eq("br_lu_flush_cnt", 32'(flush_cnt), 32'd1);
        check_eq("br_lu_stall_cnt", 32'(stall_cnt), 32'd2);

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
            cycle("mem_wait");
        end
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
        cycle("mem_done");
        check_eq("mem_wait_stall_cnt", 32'(stall_cnt), 32'd5);
        cycle("mem_fast");
        check_eq("mem_fast_stall_cnt", 32'(stall_cnt), 32'd5);

        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0);
        cycle("br_under_memstall");
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1);
        cycle("br_after_mem");
        check_eq("br_after_mem_flush_cnt", 32'(flush_cnt), 32'd2);

        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
            cycle("pre_rst_wait");
        end
        drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
        cycle("rst_in_wait");
        idle();
        cycle("post_rst");
        check_eq("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

        drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
        cycle("rst_pre_timeout");
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
            cycle("timeout_wait");
        end
        check_eq("timeout_mem_err", 32'(mem_err), 32'd1);
        check_eq("timeout_stall_cnt", 32'(stall_cnt), 32'd5);
        drive(0, 1, 5'd3, 5'd3, 1, 5'd0, 0, 1, 1, 1);
        cycle("error_br_lu");
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
        cycle("error_memstall");
        idle();
        cycle("error_idle");
        drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
        cycle("error_reset");
        idle();
        cycle("error_cleared");
        check_eq("error_cleared_mem_err", 32'(mem_err), 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 5'd9, 5'd9, 1, 5'd9, 1, 0, 0, 1);
            cycle("sat_stall");
        end
        check_eq("sat_stall_cnt", 32'(stall_cnt), 32'd15);

        for (int i = 0; i < 80; i++) begin
            drive(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(28, 31)), 5'($urandom_range(28, 31)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(28, 31)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) != 0));
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
